issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue.sv | 157 +++++++++++++++
 tb/tb_issue_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// Dual-slot in-order issue queue: circular buffer of DEPTH entries.
// Takes up to two fetched instructions per cycle and presents head and head+1 to issue.
`ifndef CTRL_BUS
`define CTRL_BUS 24
`endif

module issue_queue #(
  parameter int DEPTH = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 flush_i,
  input  logic                 in_valid0_i,
  input  logic                 in_valid1_i,
  input  logic [31:0]          in_inst0_i,
  input  logic [31:0]          in_inst1_i,
  input  logic [`CTRL_BUS-1:0] in_ctrl0_i,
  input  logic [`CTRL_BUS-1:0] in_ctrl1_i,
  input  logic                 in_pred_0_i,
  input  logic                 in_pred_1_i,
  input  logic [31:0]          in_pred_tgt_0_i,
  input  logic [31:0]          in_pred_tgt_1_i,
  input  logic [31:0]          in_pc_0_i,
  input  logic [31:0]          in_pc_1_i,
  output logic                 in_ready_o,
  output logic [31:0]          inst0_o,
  output logic [`CTRL_BUS-1:0] ctrl0_o,
  output logic                 pred_0_o,
  output logic [31:0]          pred_tgt_0_o,
  output logic [31:0]          pc_0_o,
  output logic [31:0]          inst1_o,
  output logic [`CTRL_BUS-1:0] ctrl1_o,
  output logic                 pred_1_o,
  output logic [31:0]          pred_tgt_1_o,
  output logic [31:0]          pc_1_o,
  output logic                 valid0_o,
  output logic                 valid1_o,
  input  logic                 pop0_i,
  input  logic                 pop1_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NopInst = 32'h00000013;

  typedef struct packed {
    logic [31:0]          inst;
    logic [`CTRL_BUS-1:0] ctrl;
    logic                 pred;
    logic [31:0]          predTgt;
    logic [31:0]          pc;
  } entry_t;

  entry_t        storage_q [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;

  logic          doPush;
  logic [1:0]    numPush;
  logic [1:0]    numPop;
  logic          headValid;
  logic          nextValid;
  entry_t        pushEntry0, pushEntry1;
  entry_t        headEntry, nextEntry;
  entry_t        slot0, slot1;

  // Ready depends only on registered occupancy so a pop never feeds back into ready.
  assign headValid  = count_q >= CW'(1);
  assign nextValid  = count_q >= CW'(2);
  assign in_ready_o = count_q <= CW'(DEPTH - 2);
  assign doPush     = in_ready_o && in_valid0_i && !flush_i;

  assign pushEntry0 = '{inst: in_inst0_i, ctrl: in_ctrl0_i, pred: in_pred_0_i,
                        predTgt: in_pred_tgt_0_i, pc: in_pc_0_i};
  assign pushEntry1 = '{inst: in_inst1_i, ctrl: in_ctrl1_i, pred: in_pred_1_i,
                        predTgt: in_pred_tgt_1_i, pc: in_pc_1_i};

  always_comb begin
    numPush = 2'd0;
    if (doPush) begin
      numPush = in_valid1_i ? 2'd2 : 2'd1;
    end

    numPop = 2'd0;
    if (pop0_i && headValid) begin
      numPop = (pop1_i && nextValid) ? 2'd2 : 2'd1;
    end

    rdPtr_d = rdPtr_q + PW'(numPop);
    wrPtr_d = wrPtr_q + PW'(numPush);
    count_d = count_q + CW'(numPush) - CW'(numPop);

    // A redirect wipes everything, including whatever arrives or leaves this cycle.
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (doPush) begin
      storage_q[wrPtr_q] <= pushEntry0;
      if (in_valid1_i) begin
        storage_q[wrPtr_q + PW'(1)] <= pushEntry1;
      end
    end
  end

  assign headEntry = storage_q[rdPtr_q];
  assign nextEntry = storage_q[rdPtr_q + PW'(1)];

  // Empty slots show a NOP with zeroed side data rather than stale storage.
  always_comb begin
    slot0      = '0;
    slot0.inst = NopInst;
    slot1      = '0;
    slot1.inst = NopInst;
    if (headValid) begin
      slot0 = headEntry;
    end
    if (nextValid) begin
      slot1 = nextEntry;
    end
  end

  assign inst0_o      = slot0.inst;
  assign ctrl0_o      = slot0.ctrl;
  assign pred_0_o     = slot0.pred;
  assign pred_tgt_0_o = slot0.predTgt;
  assign pc_0_o       = slot0.pc;

  assign inst1_o      = slot1.inst;
  assign ctrl1_o      = slot1.ctrl;
  assign pred_1_o     = slot1.pred;
  assign pred_tgt_1_o = slot1.predTgt;
  assign pc_1_o       = slot1.pc;

  assign valid0_o = headValid;
  assign valid1_o = nextValid;
  assign count_o  = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed corner cases followed by random traffic,
// compared against a queue-based model of the instruction stream.
`ifndef CTRL_BUS
`define CTRL_BUS 24
`endif

module tb_issue_queue;

  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int CB = `CTRL_BUS;

  typedef struct packed {
    logic [31:0]   inst;
    logic [CB-1:0] ctrl;
    logic          pred;
    logic [31:0]   tgt;
    logic [31:0]   pc;
  } entry_t;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          flush = 1'b0;
  logic          inValid0 = 1'b0, inValid1 = 1'b0;
  entry_t        in0 = '0, in1 = '0;
  logic          pop0 = 1'b0, pop1 = 1'b0;
  logic          inReady, valid0, valid1;
  logic [31:0]   inst0, inst1, predTgt0, predTgt1, pc0, pc1;
  logic [CB-1:0] ctrl0, ctrl1;
  logic          pred0, pred1;
  logic [CW-1:0] count;

  entry_t modelQ[$];
  int     errors = 0;
  int     checks = 0;
  logic [31:0] nextPc = 32'h1000;

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clock_i(clock), .reset_n_i(resetN), .flush_i(flush),
    .in_valid0_i(inValid0), .in_valid1_i(inValid1),
    .in_inst0_i(in0.inst), .in_inst1_i(in1.inst),
    .in_ctrl0_i(in0.ctrl), .in_ctrl1_i(in1.ctrl),
    .in_pred_0_i(in0.pred), .in_pred_1_i(in1.pred),
    .in_pred_tgt_0_i(in0.tgt), .in_pred_tgt_1_i(in1.tgt),
    .in_pc_0_i(in0.pc), .in_pc_1_i(in1.pc),
    .in_ready_o(inReady),
    .inst0_o(inst0), .ctrl0_o(ctrl0), .pred_0_o(pred0), .pred_tgt_0_o(predTgt0), .pc_0_o(pc0),
    .inst1_o(inst1), .ctrl1_o(ctrl1), .pred_1_o(pred1), .pred_tgt_1_o(predTgt1), .pc_1_o(pc1),
    .valid0_o(valid0), .valid1_o(valid1),
    .pop0_i(pop0), .pop1_i(pop1),
    .count_o(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [159:0] observed, input logic [159:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic entry_t mkEntry(input logic [31:0] pc);
    entry_t e;
    e.inst = $urandom;
    e.ctrl = CB'($urandom);
    e.pred = 1'($urandom);
    e.tgt  = $urandom;
    e.pc   = pc;
    return e;
  endfunction

  function automatic logic [159:0] expSlot(input int idx);
    entry_t nop;
    nop = '0;
    nop.inst = 32'h00000013;
    if (modelQ.size() > idx) return 160'(modelQ[idx]);
    return 160'(nop);
  endfunction

  // Everything expected here comes from the model queue: occupancy is its size, slots are its front.
  task automatic checkOutput(input string tag);
    int n;
    n = modelQ.size();
    check({tag, " count"}, 160'(count), 160'(n));
    check({tag, " ready"}, 160'(inReady), 160'((DEPTH - n) >= 2));
    check({tag, " valid0"}, 160'(valid0), 160'(n >= 1));
    check({tag, " valid1"}, 160'(valid1), 160'(n >= 2));
    check({tag, " slot0"}, 160'({inst0, ctrl0, pred0, predTgt0, pc0}), expSlot(0));
    check({tag, " slot1"}, 160'({inst1, ctrl1, pred1, predTgt1, pc1}), expSlot(1));
  endtask

  // Drives one cycle of inputs from the falling edge, checks nothing leaks through
  // before the rising edge, advances the model at the edge and checks the result.
  task automatic applyStimulus(input string tag, input bit v0, input bit v1, input bit p0,
                               input bit p1, input bit fl, input entry_t e0, input entry_t e1);
    bit ready;
    int size;
    inValid0 = v0;
    inValid1 = v1;
    pop0     = p0;
    pop1     = p1;
    flush    = fl;
    in0      = e0;
    in1      = e1;
    #1;
    checkOutput({tag, " pre"});
    @(posedge clock);
    size  = modelQ.size();
    ready = (DEPTH - size) >= 2;
    if (fl) begin
      modelQ.delete();
    end else begin
      if (p0 && size >= 1) void'(modelQ.pop_front());
      if (p0 && p1 && size >= 2) void'(modelQ.pop_front());
      if (ready && v0) begin
        modelQ.push_back(e0);
        if (v1) modelQ.push_back(e1);
      end
    end
    @(negedge clock);
    checkOutput(tag);
  endtask

  task automatic pushPair(input string tag, input logic [31:0] pcA, input logic [31:0] pcB);
    applyStimulus(tag, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mkEntry(pcA), mkEntry(pcB));
  endtask

  task automatic pushOne(input string tag, input logic [31:0] pcA);
    applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mkEntry(pcA), mkEntry(32'h0));
  endtask

  task automatic pop(input string tag, input bit both);
    applyStimulus(tag, 1'b0, 1'b0, 1'b1, both, 1'b0, '0, '0);
  endtask

  task automatic doFlush(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  initial begin
    bit v0, v1, p0, p1, fl;
    $display("[TB] issue_queue bench start");
    repeat (2) @(negedge clock);
    checkOutput("reset");
    resetN = 1'b1;

    // Basic pair push, then in-order partial issue.
    pushPair("pairPush", 32'h100, 32'h104);
    check("pairPush pc0", 160'(pc0), 160'(32'h100));
    check("pairPush pc1", 160'(pc1), 160'(32'h104));
    pushOne("thirdPush", 32'h108);
    pop("partialIssue", 1'b0);
    check("partialIssue pc0", 160'(pc0), 160'(32'h104));
    check("partialIssue pc1", 160'(pc1), 160'(32'h108));

    // Fill to capacity, a dropped push, then drain two.
    doFlush("flushA");
    for (int i = 0; i < 4; i++) pushPair("fill", 32'h300 + 8 * i, 32'h304 + 8 * i);
    check("full count", 160'(count), 160'(8));
    check("full ready", 160'(inReady), 160'(0));
    pushPair("dropped", 32'h400, 32'h404);
    pop("drainTwo", 1'b1);
    check("drain count", 160'(count), 160'(6));
    check("drain ready", 160'(inReady), 160'(1));

    // Pointer wrap: fill 8, pop 7, then push a pair.
    doFlush("flushB");
    for (int i = 0; i < 4; i++) pushPair("wrapFill", 32'h500 + 8 * i, 32'h504 + 8 * i);
    for (int i = 0; i < 3; i++) pop("wrapPop", 1'b1);
    pop("wrapPopOne", 1'b0);
    pushPair("wrapPush", 32'h200, 32'h204);
    check("wrap head", 160'(pc0), 160'(32'h51c));
    check("wrap next", 160'(pc1), 160'(32'h200));
    pop("wrapIssue", 1'b0);
    check("wrap tail0", 160'(pc0), 160'(32'h200));
    check("wrap tail1", 160'(pc1), 160'(32'h204));

    // Flush overrides a same-cycle push and pop.
    doFlush("flushC");
    pushPair("pre3a", 32'h600, 32'h604);
    pushOne("pre3b", 32'h608);
    applyStimulus("flushOverride", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, mkEntry(32'h700), mkEntry(32'h704));
    check("flushOverride inst0", 160'(inst0), 160'(32'h00000013));

    // Popping two with only one entry must not underflow.
    pushOne("single", 32'h800);
    pop("underflow", 1'b1);
    check("underflow count", 160'(count), 160'(0));

    // Reset mid-stream clears outputs without waiting for a clock edge.
    pushPair("preReset", 32'h900, 32'h904);
    inValid0 = 1'b0;
    inValid1 = 1'b0;
    pop0 = 1'b0;
    pop1 = 1'b0;
    #2 resetN = 1'b0;
    #1 modelQ.delete();
    checkOutput("midReset");
    @(negedge clock);
    resetN = 1'b1;
    pushPair("postReset", 32'ha00, 32'ha04);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      v0 = ($urandom_range(3) != 0);
      v1 = v0 && ($urandom_range(1) == 1);
      p0 = ($urandom_range(1) == 1);
      p1 = p0 && ($urandom_range(1) == 1);
      fl = ($urandom_range(39) == 0);
      applyStimulus("random", v0, v1, p0, p1, fl, mkEntry(nextPc), mkEntry(nextPc + 4));
      nextPc = nextPc + 8;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
